// File: rtl/regfile_arb_pkg.sv
// Shared types for the register file access arbiter:
// FSM states, requester ids and the index-to-select decode.
package regfile_arb_pkg;

  localparam int MAX_HEIGHT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    ACK
  } state_e;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_e;

  // One-hot select for idx; all zero when idx is past the file.
  function automatic logic [MAX_HEIGHT-1:0] idx2onehot(
    input logic [3:0]  idx,
    input int unsigned height
  );
    logic [MAX_HEIGHT-1:0] oh;
    oh = '0;
    if (32'(idx) < height) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Requester-side handshake bundle: level req with we/idx/wdata,
// answered by a one-cycle ack with err. master = requester.
interface regfile_access_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
);

  logic             req;
  logic             we;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic             err;

  modport master (
    output req, we, idx, wdata,
    input  ack, err
  );

  modport slave (
    input  req, we, idx, wdata,
    output ack, err
  );

endinterface

// File: rtl/regfile_access_arbiter_rr.sv
// rr_arbiter_2: two-input round-robin arbiter. Ports: req_a/b in,
// en (commit grant), gnt_a/b out. Last-grant flop resets to B.
module rr_arbiter_2
  import regfile_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic en,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_e last_q;
  req_id_e last_d;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      (req_a && req_b): begin
        gnt_a = (last_q == REQ_B);
        gnt_b = (last_q == REQ_A);
      end
      (req_a && !req_b): gnt_a = 1'b1;
      (!req_a && req_b): gnt_b = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (en && gnt_a) last_d = REQ_A;
    if (en && gnt_b) last_d = REQ_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Serialises A/B register file requests onto one file port.
// Ports: Clk, Rst_n, port_a/port_b (slave), Rdata, RfCs/RfEn/RfIn, RfOut.
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 3,
  parameter int IDXW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  regfile_access_arbiter_if.slave  port_a,
  regfile_access_arbiter_if.slave  port_b,
  output logic [WIDTH-1:0]         Rdata,
  output logic [HEIGHT-1:0]        RfCs,
  output logic                     RfEn,
  output logic [WIDTH-1:0]         RfIn,
  input  logic [WIDTH-1:0]         RfOut
);

  state_e            state_q, state_d;
  req_id_e           who_q, who_d;
  logic              we_q, we_d;
  logic [HEIGHT-1:0] rf_cs_q, rf_cs_d;
  logic [WIDTH-1:0]  rf_in_q, rf_in_d;
  logic              rf_en_q, rf_en_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              err_a_q, err_a_d;
  logic              err_b_q, err_b_d;

  logic              gnt_a, gnt_b;
  logic              g_we;
  logic [IDXW-1:0]   g_idx;
  logic [WIDTH-1:0]  g_wdata;
  logic              g_ok;

  rr_arbiter_2 u_rr (
    .clk   (Clk),
    .rst_n (Rst_n),
    .req_a (port_a.req),
    .req_b (port_b.req),
    .en    (state_q == IDLE),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  always_comb begin
    g_we    = gnt_a ? port_a.we    : port_b.we;
    g_idx   = gnt_a ? port_a.idx   : port_b.idx;
    g_wdata = gnt_a ? port_a.wdata : port_b.wdata;
    g_ok    = 32'(g_idx) < 32'(HEIGHT);
  end

  always_comb begin
    state_d = state_q;
    who_d   = who_q;
    we_d    = we_q;
    rf_cs_d = rf_cs_q;
    rf_in_d = rf_in_q;
    rf_en_d = 1'b0;
    rdata_d = rdata_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    err_a_d = 1'b0;
    err_b_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_a || gnt_b) begin
          who_d = gnt_a ? REQ_A : REQ_B;
          we_d  = g_we;
          if (!g_ok) begin
            // Out-of-range index: answer at once, file untouched.
            state_d = ACK;
            ack_a_d = gnt_a;
            ack_b_d = gnt_b;
            err_a_d = gnt_a;
            err_b_d = gnt_b;
          end else begin
            state_d = SETUP;
            rf_cs_d = HEIGHT'(idx2onehot(4'(g_idx), HEIGHT));
            rf_in_d = g_wdata;
          end
        end
      end
      SETUP: begin
        if (we_q) begin
          state_d = STROBE;
          rf_en_d = 1'b1;
        end else begin
          state_d = ACK;
          rdata_d = RfOut;
          ack_a_d = (who_q == REQ_A);
          ack_b_d = (who_q == REQ_B);
        end
      end
      STROBE: begin
        state_d = ACK;
        ack_a_d = (who_q == REQ_A);
        ack_b_d = (who_q == REQ_B);
      end
      ACK: begin
        // Cs was held through this cycle, past the falling strobe.
        state_d = IDLE;
        rf_cs_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      who_q   <= REQ_A;
      we_q    <= 1'b0;
      rf_cs_q <= '0;
      rf_in_q <= '0;
      rf_en_q <= 1'b0;
      rdata_q <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      err_a_q <= 1'b0;
      err_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      who_q   <= who_d;
      we_q    <= we_d;
      rf_cs_q <= rf_cs_d;
      rf_in_q <= rf_in_d;
      rf_en_q <= rf_en_d;
      rdata_q <= rdata_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      err_a_q <= err_a_d;
      err_b_q <= err_b_d;
    end
  end

  assign Rdata      = rdata_q;
  assign RfCs       = rf_cs_q;
  assign RfEn       = rf_en_q;
  assign RfIn       = rf_in_q;
  assign port_a.ack = ack_a_q;
  assign port_a.err = err_a_q;
  assign port_b.ack = ack_b_q;
  assign port_b.err = err_b_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: directed steps plus random rounds
// against a transaction-level model of file contents and arbitration.
module tb_regfile_access_arbiter;

  localparam int W  = 8;
  localparam int H  = 3;
  localparam int IW = 2;

  typedef struct {
    bit            we;
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } op_t;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic [W-1:0] Rdata;
  logic [H-1:0] RfCs;
  logic         RfEn;
  logic [W-1:0] RfIn;
  logic [W-1:0] RfOut;

  always #5 Clk = ~Clk;

  regfile_access_arbiter_if #(.WIDTH(W), .IDXW(IW)) a_if ();
  regfile_access_arbiter_if #(.WIDTH(W), .IDXW(IW)) b_if ();

  regfile_access_arbiter #(.WIDTH(W), .HEIGHT(H)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .port_a (a_if),
    .port_b (b_if),
    .Rdata  (Rdata),
    .RfCs   (RfCs),
    .RfEn   (RfEn),
    .RfIn   (RfIn),
    .RfOut  (RfOut)
  );

  // Register file: latches on rising En, cleared by the shared reset.
  logic [W-1:0] file_q [H];
  always @(posedge RfEn or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < H; i++) file_q[i] <= '0;
    end else begin
      for (int i = 0; i < H; i++) if (RfCs[i]) file_q[i] <= RfIn;
    end
  end

  always_comb begin
    RfOut = '0;
    for (int i = 0; i < H; i++) if (RfCs[i]) RfOut = RfOut | file_q[i];
  end

  // Bus monitor: strobe count, acks, and Cs/In stability around En.
  int           en_pulses = 0;
  int           ack_a_cnt = 0;
  int           cs_viol   = 0;
  logic         prev_en;
  logic [H-1:0] prev_cs;
  logic [W-1:0] prev_in;

  always @(negedge Clk) begin
    if (Rst_n === 1'b1) begin
      if (RfEn && !prev_en) begin
        en_pulses++;
        if (prev_cs !== RfCs || prev_in !== RfIn || $countones(RfCs) != 1)
          cs_viol++;
      end
      if (!RfEn && prev_en && prev_cs !== RfCs) cs_viol++;
      if (a_if.ack) ack_a_cnt++;
    end
    prev_en = RfEn;
    prev_cs = RfCs;
    prev_in = RfIn;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: file contents, last read value, last winner.
  logic [W-1:0] mdl_mem [H];
  logic [W-1:0] mdl_rdata;
  bit           mdl_last_b;

  task automatic mdl_reset();
    for (int i = 0; i < H; i++) mdl_mem[i] = '0;
    mdl_rdata  = '0;
    mdl_last_b = 1'b1;
  endtask

  function automatic int lat(input op_t o);
    if (int'(o.idx) >= H) return 1;
    return o.we ? 3 : 2;
  endfunction

  task automatic mdl_apply(input op_t o);
    if (int'(o.idx) < H) begin
      if (o.we) mdl_mem[o.idx] = o.data;
      else      mdl_rdata      = mdl_mem[o.idx];
    end
  endtask

  function automatic int nwr(input bit r, input op_t o);
    return (r && o.we && int'(o.idx) < H) ? 1 : 0;
  endfunction

  // One arbitration round from IDLE; returns one cycle after last ACK.
  task automatic run_round(input bit ra, input bit rb,
                           input op_t oa, input op_t ob);
    int  order[$];
    int  served = 0;
    int  gap = 0;
    int  n;
    int  who;
    int  en0;
    op_t o;
    if (ra && rb) begin
      if (mdl_last_b) order = '{0, 1};
      else            order = '{1, 0};
    end else if (ra) order = '{0};
    else             order = '{1};
    n = order.size();
    mdl_last_b = (order[n-1] == 1);
    en0 = en_pulses;
    a_if.req = ra; a_if.we = oa.we; a_if.idx = oa.idx; a_if.wdata = oa.data;
    b_if.req = rb; b_if.we = ob.we; b_if.idx = ob.idx; b_if.wdata = ob.data;
    for (int c = 0; c < 40 && served < n; c++) begin
      @(posedge Clk); #1;
      gap++;
      if (a_if.ack || b_if.ack) begin
        who = a_if.ack ? 0 : 1;
        o = (order[served] == 0) ? oa : ob;
        chk("single_ack", 32'(a_if.ack && b_if.ack), 0);
        chk("ack_order", who, order[served]);
        chk("latency", gap, (served == 0) ? lat(o) : 1 + lat(o));
        mdl_apply(o);
        chk("err", (who == 0) ? a_if.err : b_if.err,
            32'(int'(o.idx) >= H));
        chk("rdata", Rdata, mdl_rdata);
        if (who == 0) a_if.req = 1'b0;
        else          b_if.req = 1'b0;
        served++;
        gap = 0;
      end
    end
    chk("served", served, n);
    chk("en_pulses", en_pulses - en0, nwr(ra, oa) + nwr(rb, ob));
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    @(posedge Clk); #1;
  endtask

  function automatic op_t mk(input bit we, input int idx, input int d);
    op_t o;
    o.we   = we;
    o.idx  = IW'(idx);
    o.data = W'(d);
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t oa, ob;
    int  acks0, en0, cyc;
    logic [W-1:0] r0;

    a_if.req = 0; a_if.we = 0; a_if.idx = '0; a_if.wdata = '0;
    b_if.req = 0; b_if.we = 0; b_if.idx = '0; b_if.wdata = '0;
    Rst_n = 1'b1;
    mdl_reset();
    #2 Rst_n = 1'b0;
    #20;
    chk("rst_cs", RfCs, 0);
    chk("rst_en", RfEn, 0);
    chk("rst_in", RfIn, 0);
    chk("rst_rdata", Rdata, 0);
    chk("rst_ack", {a_if.ack, b_if.ack}, 0);
    chk("rst_err", {a_if.err, b_if.err}, 0);
    @(negedge Clk) Rst_n = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("idle_no_en", en_pulses, 0);
    chk("idle_cs", RfCs, 0);

    // Directed write A idx2 = 0x5A, edge by edge.
    a_if.req = 1; a_if.we = 1; a_if.idx = 2; a_if.wdata = 8'h5A;
    @(posedge Clk); #1;
    chk("w_setup_cs", RfCs, 3'b100);
    chk("w_setup_en", RfEn, 0);
    chk("w_setup_in", RfIn, 8'h5A);
    @(posedge Clk); #1;
    chk("w_strobe_en", RfEn, 1);
    chk("w_strobe_cs", RfCs, 3'b100);
    chk("w_strobe_ack", a_if.ack, 0);
    @(posedge Clk); #1;
    chk("w_ack", a_if.ack, 1);
    chk("w_ack_en", RfEn, 0);
    chk("w_ack_cs", RfCs, 3'b100);
    chk("w_ack_err", a_if.err, 0);
    a_if.req = 0;
    @(posedge Clk); #1;
    chk("w_idle_cs", RfCs, 0);
    mdl_mem[2] = 8'h5A;
    mdl_last_b = 1'b0;

    run_round(1, 0, mk(0, 2, 0), mk(0, 0, 0));

    // Contention, twice, then read back.
    run_round(1, 1, mk(1, 0, 'h11), mk(1, 1, 'h22));
    run_round(1, 1, mk(1, 0, 'h11), mk(1, 1, 'h22));
    run_round(1, 0, mk(0, 0, 0), mk(0, 0, 0));
    run_round(0, 1, mk(0, 0, 0), mk(0, 1, 0));

    // Out-of-range index from B, read and write.
    r0 = Rdata;
    run_round(0, 1, mk(0, 0, 0), mk(0, 3, 0));
    run_round(0, 1, mk(0, 0, 0), mk(1, 3, 'hEE));
    chk("inv_rdata_hold", Rdata, r0);

    // Back-to-back reads: A holds req through its ack.
    a_if.req = 1; a_if.we = 0; a_if.idx = 0;
    cyc = 0;
    do begin
      @(posedge Clk); #1;
      cyc++;
    end while (!a_if.ack && cyc < 10);
    chk("b2b_first_ack", a_if.ack, 1);
    chk("b2b_first", Rdata, mdl_mem[0]);
    a_if.idx = 1;
    @(posedge Clk); #1;
    chk("b2b_hold_idle", Rdata, mdl_mem[0]);
    chk("b2b_no_ack", a_if.ack, 0);
    @(posedge Clk); #1;
    chk("b2b_hold_setup", Rdata, mdl_mem[0]);
    @(posedge Clk); #1;
    chk("b2b_second_ack", a_if.ack, 1);
    chk("b2b_second", Rdata, mdl_mem[1]);
    a_if.req = 0;
    mdl_rdata  = mdl_mem[1];
    mdl_last_b = 1'b0;
    @(posedge Clk); #1;

    // Reset while the strobe is high.
    a_if.req = 1; a_if.we = 1; a_if.idx = 1; a_if.wdata = 8'h77;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("mid_strobe", RfEn, 1);
    acks0 = ack_a_cnt;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_en", RfEn, 0);
    chk("mid_rst_cs", RfCs, 0);
    chk("mid_rst_ack", a_if.ack, 0);
    chk("mid_rst_rdata", Rdata, 0);
    a_if.req = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("mid_rst_no_ack", ack_a_cnt, acks0);
    mdl_reset();
    run_round(1, 0, mk(0, 1, 0), mk(0, 0, 0));

    // Random rounds.
    for (int r = 0; r < 40; r++) begin
      int m;
      m  = $urandom_range(1, 3);
      oa = mk(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
      ob = mk(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
      run_round(m[0], m[1], oa, ob);
    end

    en0 = en_pulses;
    chk("cs_stability", cs_viol, 0);
    chk("end_idle_en", RfEn, 0);
    chk("end_pulses", en_pulses, en0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
